// File: rtl/regbank_alu_if.sv
// regbank_alu_if: controller-facing bus of the register bank / ALU datapath.
// Carries the register selects, the ALU opcode, the port-register load
// strobe and data, and returns the registered status flags and R0.
//   master : controller side (drives selects/load/ports, reads flags/R0)
//   slave  : datapath side
interface regbank_alu_if #(
    parameter int DATAWIDTH     = 8,
    parameter int SELECTIONALU  = 3,
    parameter int SELECTIONDECO = 3
);
    logic [SELECTIONDECO-1:0] sSelDecoA;
    logic [SELECTIONDECO-1:0] sSelDecoB;
    logic [SELECTIONDECO-1:0] sSelDecoC;
    logic [SELECTIONALU-1:0]  sSelAlu;
    logic                     sLoad;
    logic [DATAWIDTH-1:0]     sPort0In;
    logic [DATAWIDTH-1:0]     sPort1In;
    logic                     sOverflow;
    logic                     sCarry;
    logic                     sNegative;
    logic                     sZero;
    logic [DATAWIDTH-1:0]     sDataOut;

    modport master (
        output sSelDecoA, sSelDecoB, sSelDecoC, sSelAlu, sLoad, sPort0In, sPort1In,
        input  sOverflow, sCarry, sNegative, sZero, sDataOut
    );

    modport slave (
        input  sSelDecoA, sSelDecoB, sSelDecoC, sSelAlu, sLoad, sPort0In, sPort1In,
        output sOverflow, sCarry, sNegative, sZero, sDataOut
    );
endinterface

// File: rtl/regbank_alu_datapath.sv
// regbank_alu_datapath: six general registers R0..R5, two externally loaded
// port registers RP0/RP1, an 8-function ALU and a registered flag bank.
// Ports:
//   clk     system clock, all state changes on the rising edge
//   lowRst  asynchronous active-low reset
//   bus     regbank_alu_if.slave: selects A/B/C, ALU op, load strobe and
//           port data in; V/C/N/Z flags and R0 (sDataOut) out
// Register map for A/B: 0..5 = R0..R5, 6 = RP0, 7 = RP1.
// C codes 6/7 suppress the write (and the flag update).
module regbank_alu_datapath #(
    parameter int DATAWIDTH     = 8,
    parameter int SELECTIONALU  = 3,
    parameter int SELECTIONDECO = 3
) (
    input  logic          clk,
    input  logic          lowRst,
    regbank_alu_if.slave  bus
);
    localparam int NREG = 6;
    localparam int MSB  = DATAWIDTH - 1;

    logic [NREG-1:0][DATAWIDTH-1:0] regs;
    logic [DATAWIDTH-1:0]           rp0, rp1;
    logic [DATAWIDTH-1:0]           opa, opb, res;
    logic                           carry, ovf, wr_en;
    logic                           fv, fc, fn, fz;

    function automatic logic [DATAWIDTH-1:0] rd(
        input logic [SELECTIONDECO-1:0]     sel,
        input logic [NREG-1:0][DATAWIDTH-1:0] r,
        input logic [DATAWIDTH-1:0]         p0,
        input logic [DATAWIDTH-1:0]         p1
    );
        logic [DATAWIDTH-1:0] v;
        v = p1;
        if (32'(sel) < NREG) v = r[sel];
        else if (32'(sel) == NREG) v = p0;
        return v;
    endfunction

    // Reads come straight off the current state, so a write or load on an
    // edge is only seen by reads in the following cycle.
    assign opa   = rd(bus.sSelDecoA, regs, rp0, rp1);
    assign opb   = rd(bus.sSelDecoB, regs, rp0, rp1);
    assign wr_en = 32'(bus.sSelDecoC) < NREG;

    always_comb begin
        logic [DATAWIDTH:0] wide;
        res   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        wide  = '0;
        case (32'(bus.sSelAlu))
            0: res = opa;
            1: res = opb;
            2: begin
                wide  = {1'b0, opa} + {1'b0, opb};
                res   = wide[MSB:0];
                carry = wide[DATAWIDTH];
                ovf   = (opa[MSB] == opb[MSB]) && (res[MSB] != opa[MSB]);
            end
            3: begin
                res   = opa - opb;
                carry = opa >= opb;            // no borrow
                ovf   = (opa[MSB] != opb[MSB]) && (res[MSB] != opa[MSB]);
            end
            4: res = opa & opb;
            5: res = opa | opb;
            6: res = opa ^ opb;
            default: res = ~opa;
        endcase
    end

    always_ff @(posedge clk or negedge lowRst) begin
        if (!lowRst) begin
            regs <= '0;
            rp0  <= '0;
            rp1  <= '0;
            fv   <= 1'b0;
            fc   <= 1'b0;
            fn   <= 1'b0;
            fz   <= 1'b0;
        end else begin
            // Flags track only results that actually land in a register.
            if (wr_en) begin
                regs[bus.sSelDecoC] <= res;
                fv <= ovf;
                fc <= carry;
                fn <= res[MSB];
                fz <= (res == '0);
            end
            if (bus.sLoad) begin
                rp0 <= bus.sPort0In;
                rp1 <= bus.sPort1In;
            end
        end
    end

    assign bus.sOverflow = fv;
    assign bus.sCarry    = fc;
    assign bus.sNegative = fn;
    assign bus.sZero     = fz;
    assign bus.sDataOut  = regs[0];
endmodule

// File: tb/tb_regbank_alu_datapath.sv
// Randomized + directed bench for regbank_alu_datapath with an integer
// reference model of the register file and flags.
module tb_regbank_alu_datapath;
    logic clk = 1'b0;
    logic lowRst;
    always #5 clk = ~clk;

    regbank_alu_if #(.DATAWIDTH(8), .SELECTIONALU(3), .SELECTIONDECO(3)) bus();

    regbank_alu_datapath #(.DATAWIDTH(8), .SELECTIONALU(3), .SELECTIONDECO(3)) dut (
        .clk    (clk),
        .lowRst (lowRst),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // model: index 0..5 = R0..R5, 6 = RP0, 7 = RP1
    int m_r[8];
    bit m_v, m_c, m_n, m_z;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_r[i] = 0;
        {m_v, m_c, m_n, m_z} = 4'b0000;
    endtask

    function automatic int sgn(input int x);
        return (x > 127) ? x - 256 : x;
    endfunction

    task automatic model_step(input int a, b, c, alu, ld, p0, p1);
        int x, y, res, s;
        bit co, ov;
        x = m_r[a]; y = m_r[b]; co = 0; ov = 0; res = 0;
        case (alu)
            0: res = x;
            1: res = y;
            2: begin res = x + y; co = res > 255; s = sgn(x) + sgn(y); ov = (s > 127) || (s < -128); end
            3: begin res = x - y; co = x >= y;    s = sgn(x) - sgn(y); ov = (s > 127) || (s < -128); end
            4: res = x & y;
            5: res = x | y;
            6: res = x ^ y;
            default: res = 255 - x;
        endcase
        res = res & 255;
        if (c < 6) begin
            m_r[c] = res;
            m_v = ov; m_c = co; m_n = res >= 128; m_z = res == 0;
        end
        if (ld != 0) begin
            m_r[6] = p0;
            m_r[7] = p1;
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, "_dout"}, 32'(bus.sDataOut), 32'(m_r[0]));
        chk({tag, "_flags"}, 32'({bus.sOverflow, bus.sCarry, bus.sNegative, bus.sZero}),
            32'({m_v, m_c, m_n, m_z}));
    endtask

    // Drive one cycle of controller commands, advance the model on the edge.
    task automatic step(input int a, b, c, alu, ld, p0, p1);
        bus.sSelDecoA = 3'(a);
        bus.sSelDecoB = 3'(b);
        bus.sSelDecoC = 3'(c);
        bus.sSelAlu   = 3'(alu);
        bus.sLoad     = 1'(ld);
        bus.sPort0In  = 8'(p0);
        bus.sPort1In  = 8'(p1);
        @(posedge clk);
        model_step(a, b, c, alu, ld, p0, p1);
        #1;
        check_outs("step");
    endtask

    task automatic mid_reset();
        #2 lowRst = 1'b0;
        #1;
        model_reset();
        chk("rst_dout", 32'(bus.sDataOut), 32'h0);
        chk("rst_flags", 32'({bus.sOverflow, bus.sCarry, bus.sNegative, bus.sZero}), 32'h0);
        lowRst = 1'b1;
        // every register must read back as 0
        for (int s = 0; s < 8; s++) begin
            step(s, 0, 0, 0, 0, 0, 0);
            chk("rst_reg", 32'(bus.sDataOut), 32'h0);
        end
    endtask

    initial begin
        model_reset();
        lowRst = 1'b0;
        step(0, 0, 7, 0, 0, 0, 0);
        chk("por_dout", 32'(bus.sDataOut), 32'h0);
        lowRst = 1'b1;

        // reset in mid-operation
        step(0, 0, 7, 0, 1, 8'h12, 8'h34);
        step(6, 7, 2, 2, 0, 0, 0);
        mid_reset();

        // load/read ordering: R3 gets the pre-load RP0
        step(6, 0, 3, 0, 1, 8'hAA, 8'h00);
        step(3, 0, 0, 0, 0, 0, 0);
        chk("ldord_old", 32'(bus.sDataOut), 32'h00);
        step(6, 0, 3, 0, 0, 0, 0);
        step(3, 0, 0, 0, 0, 0, 0);
        chk("ldord_new", 32'(bus.sDataOut), 32'hAA);

        // add
        step(0, 0, 7, 0, 1, 8'h05, 8'h03);
        step(6, 7, 0, 2, 0, 0, 0);
        chk("add_dout", 32'(bus.sDataOut), 32'h08);
        chk("add_flags", 32'({bus.sOverflow, bus.sCarry, bus.sNegative, bus.sZero}), 32'b0000);

        // carry + zero
        step(0, 0, 7, 0, 1, 8'hFF, 8'h01);
        step(6, 7, 0, 2, 0, 0, 0);
        chk("cz_dout", 32'(bus.sDataOut), 32'h00);
        chk("cz_flags", 32'({bus.sOverflow, bus.sCarry, bus.sNegative, bus.sZero}), 32'b0101);

        // signed overflow
        step(0, 0, 7, 0, 1, 8'h7F, 8'h01);
        step(6, 7, 0, 2, 0, 0, 0);
        chk("ov_dout", 32'(bus.sDataOut), 32'h80);
        chk("ov_flags", 32'({bus.sOverflow, bus.sCarry, bus.sNegative, bus.sZero}), 32'b1010);

        // subtract with borrow into R1, then a no-write op holds flags
        step(0, 0, 7, 0, 1, 8'h03, 8'h05);
        step(6, 7, 1, 3, 0, 0, 0);
        chk("sub_flags", 32'({bus.sOverflow, bus.sCarry, bus.sNegative, bus.sZero}), 32'b0010);
        step(6, 7, 7, 2, 0, 0, 0);
        chk("hold_flags", 32'({bus.sOverflow, bus.sCarry, bus.sNegative, bus.sZero}), 32'b0010);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("sub_r1", 32'(bus.sDataOut), 32'hFE);

        // self-dependent write: R0 <= R0 + R0 using the old R0 (0xFE)
        step(0, 0, 0, 2, 0, 0, 0);
        chk("self_dep", 32'(bus.sDataOut), 32'hFC);

        // random traffic, with one reset dropped in the middle
        for (int i = 0; i < 600; i++) begin
            if (i == 300) mid_reset();
            step($urandom_range(7), $urandom_range(7), $urandom_range(7), $urandom_range(7),
                 ($urandom_range(3) == 0) ? 1 : 0, $urandom_range(255), $urandom_range(255));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
